// File: rtl/epu_pkg.sv
// +----------------------------------------------------------------------+
// | epu_pkg: address map, status bit positions and FSM encodings         |
// | shared by the EPU request loader.  Revision: 1.0                     |
// +----------------------------------------------------------------------+
`default_nettype none

package epu_pkg;

  localparam int NUM_WORDS = 32;

  localparam logic [5:0] ADDR_SIG_BASE   = 6'd0;
  localparam logic [5:0] ADDR_KEY_BASE   = 6'd16;
  localparam logic [5:0] ADDR_RHASH_BASE = 6'd24;
  localparam logic [5:0] ADDR_CTRL       = 6'd32;
  localparam logic [5:0] ADDR_CLR        = 6'd33;
  localparam logic [5:0] ADDR_STATUS     = 6'd34;

  localparam int CTRL_START_BIT = 0;
  localparam int STAT_BUSY      = 0;
  localparam int STAT_DONE      = 1;
  localparam int STAT_RESULT    = 2;
  localparam int STAT_WR_ERR    = 3;
  localparam int STAT_START_ERR = 4;
  localparam int STAT_TIMEOUT   = 5;
  localparam int CLR_MASK_BIT   = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_ACK   = 2'd2,
    ST_WAIT  = 2'd3
  } state_e;

  function automatic logic is_operand_addr(input logic [5:0] addr);
    return addr < ADDR_CTRL;
  endfunction

endpackage

`default_nettype wire

// File: rtl/epu_operand_regfile.sv
// +----------------------------------------------------------------------+
// | epu_operand_regfile: 32x32 operand store with per-word load mask,    |
// | write lock and flattened sig/key/rhash outputs.  Revision: 1.0       |
// +----------------------------------------------------------------------+
`default_nettype none

module epu_operand_regfile
  import epu_pkg::*;
(
  input  logic         axiclk,
  input  logic         resetn,
  input  logic         wr_en_i,
  input  logic [5:0]   wr_addr_i,
  input  logic [31:0]  wr_data_i,
  input  logic         lock_i,
  input  logic         mask_clr_i,
  input  logic [4:0]   rd_idx_i,
  output logic [31:0]  rd_word_o,
  output logic [511:0] sig_o,
  output logic [255:0] key_o,
  output logic [255:0] rhash_o,
  output logic         mask_full_o,
  output logic         wr_drop_o
);

  logic [31:0] words_q [NUM_WORDS];
  logic [31:0] mask_q;
  logic [31:0] mask_d;
  logic        w_op_wr;
  logic        w_accept;

  assign w_op_wr   = wr_en_i && is_operand_addr(wr_addr_i);
  assign w_accept  = w_op_wr && !lock_i;
  assign wr_drop_o = w_op_wr && lock_i;

  always_ff @(posedge axiclk) begin
    if (!resetn) begin
      for (int i = 0; i < NUM_WORDS; i++) begin
        words_q[i] <= '0;
      end
    end else if (w_accept) begin
      words_q[wr_addr_i[4:0]] <= wr_data_i;
    end
  end

  // A locked (busy) loader must keep its mask so the held operands stay valid.
  always_comb begin
    mask_d = mask_q;
    if (mask_clr_i && !lock_i) begin
      mask_d = '0;
    end else if (w_accept) begin
      mask_d[wr_addr_i[4:0]] = 1'b1;
    end
  end

  always_ff @(posedge axiclk) begin
    if (!resetn) begin
      mask_q <= '0;
    end else begin
      mask_q <= mask_d;
    end
  end

  assign mask_full_o = &mask_q;
  assign rd_word_o   = words_q[rd_idx_i];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_WORDS; gi++) begin : g_flat
      if (gi < int'(ADDR_KEY_BASE)) begin : g_sig
        assign sig_o[32*gi +: 32] = words_q[gi];
      end else if (gi < int'(ADDR_RHASH_BASE)) begin : g_key
        assign key_o[32*(gi-int'(ADDR_KEY_BASE)) +: 32] = words_q[gi];
      end else begin : g_rhash
        assign rhash_o[32*(gi-int'(ADDR_RHASH_BASE)) +: 32] = words_q[gi];
      end
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/epu_request_loader.sv
// +----------------------------------------------------------------------+
// | epu_request_loader: register front end that loads EPU operands,      |
// | issues the request and reports status/irq.  Optional watchdog abort  |
// | enabled with EPU_LOADER_TIMEOUT_EN.  Revision: 1.0                   |
// +----------------------------------------------------------------------+
`default_nettype none

module epu_request_loader
  import epu_pkg::*;
#(
`ifdef EPU_LOADER_TIMEOUT_EN
  parameter logic [23:0] TIMEOUT_CYCLES = 24'hFFFFFF,
`endif
  parameter int CNT_W = 16
) (
  input  logic         axiclk,
  input  logic         resetn,
  input  logic         wr_en_i,
  input  logic [5:0]   wr_addr_i,
  input  logic [31:0]  wr_data_i,
  input  logic [5:0]   rd_addr_i,
  output logic [31:0]  rd_data_o,
  output logic [511:0] epu_sig_o,
  output logic [255:0] epu_key_o,
  output logic [255:0] epu_rhash_o,
  output logic         epu_valid_o,
  input  logic         epu_ready_i,
  input  logic         epu_result_i,
  output logic         irq_o
);

  state_e           state_q;
  state_e           state_d;
  logic             epu_valid_q;
  logic             epu_valid_d;
  logic             done_q;
  logic             result_q;
  logic             wr_err_q;
  logic             start_err_q;
  logic             timeout_q;
  logic [CNT_W-1:0] cnt_q;
  logic [31:0]      rd_data_q;
  logic [31:0]      rd_data_d;
  logic [31:0]      w_status;
  logic [31:0]      w_rd_word;
  logic             w_busy;
  logic             w_start;
  logic             w_clr;
  logic             w_go;
  logic             w_complete;
  logic             w_tmo_hit;
  logic             w_mask_full;
  logic             w_wr_drop;

  assign w_busy     = (state_q != ST_IDLE);
  assign w_start    = wr_en_i && (wr_addr_i == ADDR_CTRL) && wr_data_i[CTRL_START_BIT];
  assign w_clr      = wr_en_i && (wr_addr_i == ADDR_CLR);
  assign w_go       = w_start && !w_busy && w_mask_full;
  assign w_complete = (state_q == ST_WAIT) && epu_ready_i;

  epu_operand_regfile u_regfile (
    .axiclk      (axiclk),
    .resetn      (resetn),
    .wr_en_i     (wr_en_i),
    .wr_addr_i   (wr_addr_i),
    .wr_data_i   (wr_data_i),
    .lock_i      (w_busy),
    .mask_clr_i  (w_clr && wr_data_i[CLR_MASK_BIT]),
    .rd_idx_i    (rd_addr_i[4:0]),
    .rd_word_o   (w_rd_word),
    .sig_o       (epu_sig_o),
    .key_o       (epu_key_o),
    .rhash_o     (epu_rhash_o),
    .mask_full_o (w_mask_full),
    .wr_drop_o   (w_wr_drop)
  );

`ifdef EPU_LOADER_TIMEOUT_EN
  logic [23:0] tmo_q;

  always_ff @(posedge axiclk) begin
    if (!resetn) begin
      tmo_q <= '0;
    end else if ((state_q == ST_ACK) || (state_q == ST_WAIT)) begin
      tmo_q <= tmo_q + 24'd1;
    end else begin
      tmo_q <= '0;
    end
  end

  // A genuine completion in the same cycle wins over the abort.
  assign w_tmo_hit = ((state_q == ST_ACK) || (state_q == ST_WAIT)) &&
                     (tmo_q == TIMEOUT_CYCLES - 24'd1) && !w_complete;
`else
  assign w_tmo_hit = 1'b0;
`endif

  always_ff @(posedge axiclk) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (w_go) state_d = ST_ISSUE;
      ST_ISSUE: if (epu_ready_i) state_d = ST_ACK;
      ST_ACK: begin
        if (w_tmo_hit) state_d = ST_IDLE;
        else if (!epu_ready_i) state_d = ST_WAIT;
      end
      ST_WAIT:  if (w_complete || w_tmo_hit) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    epu_valid_d = (state_q == ST_ISSUE) && epu_ready_i;
  end

  always_ff @(posedge axiclk) begin
    if (!resetn) begin
      epu_valid_q <= 1'b0;
      done_q      <= 1'b0;
      result_q    <= 1'b0;
      wr_err_q    <= 1'b0;
      start_err_q <= 1'b0;
      timeout_q   <= 1'b0;
      cnt_q       <= '0;
    end else begin
      epu_valid_q <= epu_valid_d;

      // Completion takes priority over a same-cycle W1C of done.
      if (w_complete) begin
        result_q <= epu_result_i;
        done_q   <= 1'b1;
        cnt_q    <= cnt_q + CNT_W'(1);
      end else if (w_tmo_hit) begin
        result_q <= 1'b0;
        done_q   <= 1'b1;
      end else if (w_clr && wr_data_i[STAT_DONE]) begin
        done_q <= 1'b0;
      end

      if (w_wr_drop) wr_err_q <= 1'b1;
      else if (w_clr && wr_data_i[STAT_WR_ERR]) wr_err_q <= 1'b0;

      if (w_start && (w_busy || !w_mask_full)) start_err_q <= 1'b1;
      else if (w_clr && wr_data_i[STAT_START_ERR]) start_err_q <= 1'b0;

      if (w_tmo_hit) timeout_q <= 1'b1;
      else if (w_clr && wr_data_i[STAT_TIMEOUT]) timeout_q <= 1'b0;
    end
  end

  always_comb begin
    w_status                 = '0;
    w_status[31:16]          = 16'(cnt_q);
    w_status[STAT_BUSY]      = w_busy;
    w_status[STAT_DONE]      = done_q;
    w_status[STAT_RESULT]    = result_q;
    w_status[STAT_WR_ERR]    = wr_err_q;
    w_status[STAT_START_ERR] = start_err_q;
    w_status[STAT_TIMEOUT]   = timeout_q;
  end

  always_comb begin
    rd_data_d = '0;
    if (is_operand_addr(rd_addr_i)) begin
      rd_data_d = w_rd_word;
    end else if (rd_addr_i == ADDR_STATUS) begin
      rd_data_d = w_status;
    end
  end

  always_ff @(posedge axiclk) begin
    if (!resetn) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data_o   = rd_data_q;
  assign epu_valid_o = epu_valid_q;
  assign irq_o       = done_q;

endmodule

`default_nettype wire
